// File: rtl/logic_acc_8bit_pkg.sv
// Shared definitions for the logic accumulator slice.
// Contents:
//   DATA_W  - datapath width
//   op_e    - op-code encodings on {sel1,sel0}
//   state_e - output-stage FSM encodings
package logic_acc_8bit_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/logicUnit_8bit.sv
// Combinational bitwise logic unit.
// Ports:
//   a      in  DATA_W  operand A
//   b      in  DATA_W  operand B (ignored for OP_NOT)
//   op     in  op_e    operation select
//   result out DATA_W  bitwise result, no carry
module logicUnit_8bit
    import logic_acc_8bit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  op_e               op,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_acc_8bit.sv
// Logic accumulator with a single-entry valid/ready output stage.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | no result held, out_valid=0
// ST_FULL  | result held in f/zero/parity, out_valid=1
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake
//   x, y                operands
//   sel0, sel1          op select ({sel1,sel0})
//   use_acc             substitute accumulator for x
//   clr_acc             accumulator clear (level)
//   out_valid/out_ready result handshake
//   f, zero, parity     registered result and flags
//   op_count            accepted-beat counter (wraps)
module logic_acc_8bit
    import logic_acc_8bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic              sel0,
    input  logic              sel1,
    input  logic              use_acc,
    input  logic              clr_acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] f,
    output logic              zero,
    output logic              parity,
    output logic [DATA_W-1:0] op_count
);

    state_e            state;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] x_eff;
    logic [DATA_W-1:0] result;
    logic              accept;
    logic              transfer;
    op_e               op;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;
    assign op       = op_e'({sel1, sel0});

    // A clear coincident with an accept wins for the operand path, so the
    // accumulator contributes zero rather than its stale value.
    assign x_eff = use_acc ? (clr_acc ? '0 : acc) : x;

    logicUnit_8bit u_logic_unit (
        .a      (x_eff),
        .b      (y),
        .op     (op),
        .result (result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            f         <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
            acc       <= '0;
            op_count  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state     <= ST_FULL;
                        out_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    // Accept while FULL implies out_ready, so the old result
                    // is transferred in the same cycle the new one loads.
                    if (transfer && !accept) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                end
            endcase

            if (accept) begin
                f        <= result;
                zero     <= (result == '0);
                parity   <= ^result;
                acc      <= result;
                op_count <= op_count + 1'b1;
            end else if (clr_acc) begin
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_logic_acc_8bit.sv
module tb_logic_acc_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic [7:0] y;
    logic       sel0;
    logic       sel1;
    logic       use_acc;
    logic       clr_acc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] f;
    logic       zero;
    logic       parity;
    logic [7:0] op_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_cnt;

    always #5 clk = ~clk;

    logic_acc_8bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sel0      (sel0),
        .sel1      (sel1),
        .use_acc   (use_acc),
        .clr_acc   (clr_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .zero      (zero),
        .parity    (parity),
        .op_count  (op_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] xv, input logic [7:0] yv,
                         input logic [1:0] op, input logic ua, input logic ca);
        in_valid = v;
        x        = xv;
        y        = yv;
        {sel1, sel0} = op;
        use_acc  = ua;
        clr_acc  = ca;
    endtask

    task automatic test_reset();
        drive(1'b1, 8'hFF, 8'hFF, 2'b01, 1'b0, 1'b0);
        rst = 1'b1;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || f !== 8'h00 || zero !== 1'b1 || parity !== 1'b0 ||
            op_count !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: ov=%b f=%h z=%b p=%b cnt=%h want ov=0 f=00 z=1 p=0 cnt=00",
                     out_valid, f, zero, parity, op_count);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        exp_cnt = 8'h00;
    endtask

    task automatic test_ops_back_to_back();
        logic [7:0] exp_f [4] = '{8'h30, 8'hB7, 8'h87, 8'h4D};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hB2, 8'h35, 2'(i), 1'b0, 1'b0);
            step();
            exp_cnt++;
            total++;
            if (out_valid !== 1'b1 || f !== exp_f[i] || zero !== 1'b0 || parity !== 1'b0) begin
                bad++;
                $display("FAIL op%0d: ov=%b f=%h z=%b p=%b want ov=1 f=%h z=0 p=0",
                         i, out_valid, f, zero, parity, exp_f[i]);
            end
        end
        total++;
        if (op_count !== 8'd4) begin
            bad++;
            $display("FAIL ops_count: got %h want 04", op_count);
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ops_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 8'hFF, 8'h0F, 2'b00, 1'b0, 1'b0);
        step();
        exp_cnt++;
        // Offered beats during the stall must be refused.
        drive(1'b1, 8'h00, 8'hAA, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (f !== 8'h0F || in_ready !== 1'b0 || out_valid !== 1'b1 || zero !== 1'b0 ||
                parity !== 1'b0) begin
                bad++;
                $display("FAIL stall%0d: f=%h ir=%b ov=%b z=%b p=%b want f=0f ir=0 ov=1 z=0 p=0",
                         i, f, in_ready, out_valid, zero, parity);
            end
            step();
        end
        total++;
        if (f !== 8'h0F || out_valid !== 1'b1 || op_count !== exp_cnt) begin
            bad++;
            $display("FAIL stall_end: f=%h ov=%b cnt=%h want f=0f ov=1 cnt=%h",
                     f, out_valid, op_count, exp_cnt);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || op_count !== exp_cnt) begin
            bad++;
            $display("FAIL release: ov=%b cnt=%h want ov=0 cnt=%h", out_valid, op_count, exp_cnt);
        end
    endtask

    task automatic test_accumulate();
        logic [7:0] ys [4] = '{8'h01, 8'h02, 8'h04, 8'h07};
        logic [1:0] ops [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
        logic [7:0] ef [4] = '{8'h01, 8'h03, 8'h07, 8'h00};
        logic       ez [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       ep [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hAA, ys[i], ops[i], 1'b1, 1'b0);
            step();
            exp_cnt++;
            total++;
            if (f !== ef[i] || zero !== ez[i] || parity !== ep[i] || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL accum%0d: f=%h z=%b p=%b ov=%b want f=%h z=%b p=%b ov=1",
                         i, f, zero, parity, out_valid, ef[i], ez[i], ep[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_clr_with_accept();
        out_ready = 1'b1;
        // Load acc = F0 from X.
        drive(1'b1, 8'hF0, 8'h00, 2'b10, 1'b0, 1'b0);
        step();
        exp_cnt++;
        total++;
        if (f !== 8'hF0) begin
            bad++;
            $display("FAIL clr_setup: f=%h want f0", f);
        end
        drive(1'b1, 8'h55, 8'h10, 2'b01, 1'b1, 1'b1);
        step();
        exp_cnt++;
        total++;
        if (f !== 8'h10 || parity !== 1'b1 || zero !== 1'b0) begin
            bad++;
            $display("FAIL clr_accept: f=%h p=%b z=%b want f=10 p=1 z=0", f, parity, zero);
        end
        // Read acc back through the datapath: acc | 0.
        drive(1'b1, 8'h55, 8'h00, 2'b01, 1'b1, 1'b0);
        step();
        exp_cnt++;
        total++;
        if (f !== 8'h10 || op_count !== exp_cnt) begin
            bad++;
            $display("FAIL clr_acc_val: f=%h cnt=%h want f=10 cnt=%h", f, op_count, exp_cnt);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_wrap_and_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            drive(1'b1, 8'(i), 8'h0F, 2'b01, 1'b0, 1'b0);
            step();
        end
        total++;
        if (op_count !== 8'hFF) begin
            bad++;
            $display("FAIL count_ff: got %h want ff", op_count);
        end
        drive(1'b1, 8'h00, 8'h00, 2'b11, 1'b0, 1'b0);
        step();
        total++;
        if (op_count !== 8'h00 || f !== 8'hFF || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL count_wrap: cnt=%h f=%h ov=%b want cnt=00 f=ff ov=1",
                     op_count, f, out_valid);
        end
        // Reset while FULL with a beat offered and downstream stalled.
        out_ready = 1'b0;
        drive(1'b1, 8'h12, 8'h34, 2'b01, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || f !== 8'h00 || zero !== 1'b1 || parity !== 1'b0 ||
            op_count !== 8'h00 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_full: ov=%b f=%h z=%b p=%b cnt=%h ir=%b want ov=0 f=00 z=1 p=0 cnt=00 ir=1",
                     out_valid, f, zero, parity, op_count, in_ready);
        end
        out_ready = 1'b1;
        drive(1'b1, 8'h77, 8'h00, 2'b01, 1'b1, 1'b0);
        step();
        total++;
        if (f !== 8'h00 || zero !== 1'b1 || op_count !== 8'h01) begin
            bad++;
            $display("FAIL reset_acc: f=%h z=%b cnt=%h want f=00 z=1 cnt=01", f, zero, op_count);
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
        test_reset();
        test_ops_back_to_back();
        test_back_pressure();
        test_accumulate();
        test_clr_with_accept();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_acc_8bit.md
LOGIC_ACC_8BIT -- requirements
Module: logic_acc_8bit

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports clk and rst.
REQ-002 SHALL expose ports in this order (name, direction, width, meaning):
  clk        input   1  rising-edge clock
  rst        input   1  synchronous active-high reset
  in_valid   input   1  operand/op beat offered
  in_ready   output  1  block can accept a beat this cycle
  x          input   8  operand X
  y          input   8  operand Y
  sel0       input   1  op select bit 0
  sel1       input   1  op select bit 1
  use_acc    input   1  1: substitute accumulator for X
  clr_acc    input   1  clear accumulator (level, sampled each cycle)
  out_valid  output  1  result beat offered
  out_ready  input   1  downstream accepts result
  f          output  8  registered result
  zero       output  1  f == 8'h00
  parity     output  1  XOR-reduce of f
  op_count   output  8  accepted-beat counter

Function
REQ-003 SHALL map {sel1,sel0}: 00 AND, 01 OR, 10 XOR, 11 NOT X (Y ignored); all ops bitwise, 8-bit, no carry.
REQ-004 SHALL define accept = in_valid && in_ready; transfer = out_valid && out_ready.
REQ-005 SHALL drive in_ready = !out_valid || out_ready (combinational, single-entry pipeline, no bubble under back-pressure release).
REQ-006 SHALL use the effective X operand: acc when use_acc=1, else x; sampled in the accept cycle.
REQ-007 SHALL register the op result into f, zero, parity on accept; latency exactly 1 cycle (out_valid high the cycle after accept).
REQ-008 SHALL implement FSM states EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on accept; FULL->EMPTY on transfer without accept; FULL->FULL on transfer with accept (new result loaded) or on no transfer (outputs held stable).
REQ-009 SHALL hold f, zero, parity, out_valid unchanged while out_valid=1 and out_ready=0.
REQ-010 SHALL load acc with the op result on every accept.
REQ-011 SHALL, when clr_acc=1 without accept, set acc to 8'h00.
REQ-012 SHALL, when clr_acc=1 with accept, give clear priority for the operand: effective X = 8'h00 if use_acc=1; acc then loads the op result.
REQ-013 SHALL increment op_count by 1 on each accept, wrapping 8'hFF -> 8'h00.
REQ-014 SHALL ignore x, y, sel0, sel1, use_acc when accept=0.
REQ-015 SHALL keep zero and parity consistent with f at all times.

Reset
REQ-016 SHALL, on rst=1 at a clock edge, set state EMPTY, out_valid=0, f=8'h00, zero=1, parity=0, acc=8'h00, op_count=8'h00.
REQ-017 SHALL discard any held result and ignore in_valid in a reset cycle; in_ready SHALL be 1 in the first cycle after reset.
REQ-018 SHALL give rst priority over clr_acc, accept and transfer.

Structure
REQ-019 SHALL place op-code constants (AND=2'b00, OR=2'b01, XOR=2'b10, NOT=2'b11), FSM state encodings and data width (8) in a shared package.
REQ-020 SHALL instantiate the team's existing logicUnit_8bit as the single combinational sub-module; all sequential logic (FSM, acc, flags, counter) SHALL live in logic_acc_8bit.

Verification
REQ-021 SHALL cover: x=8'hB2, y=8'h35, ops 00/01/10/11 back-to-back, out_ready=1 -> f=30,B7,87,4D on consecutive cycles after 1-cycle latency; zero=0; parity=0,0,0,0; op_count=4.
REQ-022 SHALL cover back-pressure: accept AND(8'hFF,8'h0F), hold out_ready=0 for 3 cycles -> f=0F stable, in_ready=0, out_valid=1; release -> one transfer, no duplicate.
REQ-023 SHALL cover accumulation: clr_acc pulse, then use_acc=1 OR with y=01, 02, 04 -> f=01, 03, 07; then XOR y=07 -> f=00, zero=1, parity=0.
REQ-024 SHALL cover clr_acc coincident with accept (use_acc=1, OR, y=8'h10, acc previously 8'hF0) -> f=8'h10, acc=8'h10.
REQ-025 SHALL cover op_count wrap: 256 accepts -> op_count=8'h00; reset asserted while FULL -> next cycle out_valid=0, f=00, zero=1, acc=00, op_count=00.
